fb_arbiter: RTL and testbench
=============================

FB_ARBITER -- requirements
Module: fb_arbiter

Interface
REQ-001 SHALL have parameter FB_AW, default 11, meaning framebuffer address width in words.
REQ-002 SHALL have parameter FB_DW, default 4, meaning framebuffer word width (colour index).
REQ-003 SHALL have parameter WQ_DEPTH, default 4 (power of 2, at least 2), meaning write-queue depth.
REQ-004 SHALL have ports clk_pix (in, 1, pixel clock) and srst_n (in, 1, reset); reset srst_n, asynchronous, active-low; clock clk_pix.
REQ-005 SHALL have display-read ports rd_req (in, 1, scan-out read request), rd_addr (in, FB_AW, read address), rd_data (out, FB_DW, read data) and rd_valid (out, 1, rd_data valid).
REQ-006 SHALL have write-request ports wr_valid (in, 1, write request), wr_ready (out, 1, write accept), wr_addr (in, FB_AW, write address) and wr_data (in, FB_DW, write data).
REQ-007 SHALL have gating ports vblank (in, 1, vertical blanking level) and vb_only (in, 1, 1 = writes committed only while vblank=1).
REQ-008 SHALL have clear ports clr_req (in, 1, clear pulse), clr_data (in, FB_DW, fill value) and clr_busy (out, 1, drain or sweep in progress).
REQ-009 SHALL have RAM ports ram_en (out, 1), ram_we (out, 1), ram_addr (out, FB_AW), ram_wdata (out, FB_DW) and ram_rdata (in, FB_DW), for a single-port RAM with 1-cycle read latency.
REQ-010 SHALL have status port wq_level (out, clog2(WQ_DEPTH)+1, queue occupancy).

Function
REQ-011 SHALL drive the RAM port combinationally from a one-per-cycle slot grant, priority read > clear-sweep write > queue write.
REQ-012 SHALL grant the slot to read whenever rd_req=1: ram_en=1, ram_we=0, ram_addr=rd_addr.
REQ-013 SHALL register ram_rdata once, so rd_data/rd_valid appear exactly 2 cycles after rd_req; rd_valid=0 otherwise; rd_data holds its last value.
REQ-014 SHALL implement the write queue as a FIFO of {addr,data} with wr_ready = ~full; a push occurs on wr_valid & wr_ready.
REQ-015 SHALL pop the queue head when: state IDLE, no read, queue not empty, and (vb_only=0 or vblank=1); the pop drives ram_en=1, ram_we=1, ram_addr/ram_wdata = head.
REQ-016 SHALL allow simultaneous push and pop in one cycle, leaving wq_level unchanged; a push into a full queue is impossible because wr_ready=0.
REQ-017 SHALL wrap read and write pointers modulo WQ_DEPTH; full is pointer-equal with differing wrap bit.
REQ-018 SHALL implement FSM states IDLE, DRAIN and SWEEP.
REQ-019 SHALL transition IDLE to DRAIN on clr_req; the fill value is latched from clr_data in the same cycle.
REQ-020 SHALL force wr_ready=0 in DRAIN while pops continue per REQ-015 with the vblank gating ignored; DRAIN transitions to SWEEP in the cycle the queue is empty (DRAIN lasts 1 cycle if the queue is already empty).
REQ-021 SHALL, in SWEEP, write the latched fill value to addresses 0 to 2^FB_AW-1 ascending, one per non-read cycle (vblank ignored); wr_ready = ~full and no pops occur.
REQ-022 SHALL transition SWEEP to IDLE the cycle after the write to address 2^FB_AW-1; the sweep counter returns to 0.
REQ-023 SHALL drive clr_busy=1 in DRAIN and SWEEP; clr_req is ignored while clr_busy=1.
REQ-024 SHALL hold the sweep address stalled when a read takes the slot.

Reset
REQ-025 SHALL, on srst_n=0 (async assert, sync deassert upstream), reset: FSM to IDLE; pointers and sweep counter to 0; wq_level=0; rd_valid=0; rd_data=0; clr_busy=0; latched fill value=0.
REQ-026 SHALL force wr_ready=0 during reset; queued writes and an in-progress sweep are discarded on reset mid-operation.
REQ-027 SHALL keep ram_en=0 and ram_we=0 while srst_n=0.

Structure
REQ-028 SHALL place the FSM state enum (fbarb_state_t) and a write-entry struct (fb_wr_t: addr, data) in hdmi_pkg; FB_AW/FB_DW defaults are defined as package constants.
REQ-029 SHALL implement the queue as one sub-module, fb_wr_fifo (synchronous FIFO with push, pop, full, empty, level); the arbitration and FSM remain in fb_arbiter.

Verification
REQ-030 SHALL verify: rd_req=1 on addr 0x005 with RAM holding 0x9 -> rd_valid=1 and rd_data=0x9 exactly 2 cycles later.
REQ-031 SHALL verify: 4 writes pushed with rd_req held 1 -> wq_level=4, wr_ready=0; rd_req dropped -> 4 RAM writes in push order on consecutive cycles, wq_level returns to 0.
REQ-032 SHALL verify: vb_only=1, vblank=0, 2 writes pushed -> no ram_we; vblank raised -> both commit within 2 cycles.
REQ-033 SHALL verify: 3 entries queued, clr_req with clr_data=0x0 -> entries written first, then 2^FB_AW sweep writes of 0; clr_busy=1 throughout; wr_ready=0 only in DRAIN.
REQ-034 SHALL verify: clear sweep with rd_req toggled every other cycle -> every address 0 to 2047 written exactly once; reads return correct data with 2-cycle latency.
REQ-035 SHALL verify: srst_n pulsed low mid-SWEEP with the queue holding 2 entries -> all outputs reach their REQ-025 values, no further ram_we, clr_busy=0.

Source files
------------

// File: rtl/hdmi_pkg.sv
// Shared types and default geometry for the HDMI framebuffer path.
// Holds the arbiter FSM encoding and the write-queue entry layout.
package hdmi_pkg;

    localparam int unsigned FB_AW_DEF    = 11;
    localparam int unsigned FB_DW_DEF    = 4;
    localparam int unsigned WQ_DEPTH_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_SWEEP = 2'd2
    } fbarb_state_t;

    // Queue entry for the default framebuffer geometry
    typedef struct packed {
        logic [FB_AW_DEF-1:0] addr;
        logic [FB_DW_DEF-1:0] data;
    } fb_wr_t;

endpackage

// File: rtl/fb_wr_fifo.sv
// Synchronous write-request FIFO with wrap-bit pointers.
// The caller guarantees no push when full and no pop when empty.
module fb_wr_fifo
    import hdmi_pkg::*;
#(
    parameter type         entry_t = fb_wr_t,
    parameter int unsigned DEPTH   = WQ_DEPTH_DEF
) (
    input  logic                     clk_pix,
    input  logic                     srst_n,
    input  logic                     push_i,
    input  entry_t                   din_i,
    input  logic                     pop_i,
    output entry_t                   dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;

    logic [PW:0] wptr_q;
    logic [PW:0] rptr_q;
    entry_t      mem_q [DEPTH];

    // Pointer bookkeeping; the extra MSB distinguishes full from empty
    always_ff @(posedge clk_pix or negedge srst_n) begin
        if (!srst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push_i) begin
                wptr_q <= wptr_q + LW'(1);
            end
            if (pop_i) begin
                rptr_q <= rptr_q + LW'(1);
            end
        end
    end

    always_ff @(posedge clk_pix) begin
        if (push_i) begin
            mem_q[wptr_q[PW-1:0]] <= din_i;
        end
    end

    assign dout_o  = mem_q[rptr_q[PW-1:0]];
    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[PW] != rptr_q[PW]) && (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
    assign level_o = wptr_q - rptr_q;

endmodule

// File: rtl/fb_arbiter.sv
// Framebuffer RAM arbiter: scan-out reads beat clear-sweep writes beat queued writes,
// one RAM access per pixel clock, with vblank-gated commits and a full-screen clear.
module fb_arbiter
    import hdmi_pkg::*;
#(
    parameter int unsigned FB_AW    = FB_AW_DEF,
    parameter int unsigned FB_DW    = FB_DW_DEF,
    parameter int unsigned WQ_DEPTH = WQ_DEPTH_DEF
) (
    input  logic                        clk_pix,
    input  logic                        srst_n,
    input  logic                        rd_req,
    input  logic [FB_AW-1:0]            rd_addr,
    output logic [FB_DW-1:0]            rd_data,
    output logic                        rd_valid,
    input  logic                        wr_valid,
    output logic                        wr_ready,
    input  logic [FB_AW-1:0]            wr_addr,
    input  logic [FB_DW-1:0]            wr_data,
    input  logic                        vblank,
    input  logic                        vb_only,
    input  logic                        clr_req,
    input  logic [FB_DW-1:0]            clr_data,
    output logic                        clr_busy,
    output logic                        ram_en,
    output logic                        ram_we,
    output logic [FB_AW-1:0]            ram_addr,
    output logic [FB_DW-1:0]            ram_wdata,
    input  logic [FB_DW-1:0]            ram_rdata,
    output logic [$clog2(WQ_DEPTH):0]   wq_level
);

    typedef struct packed {
        logic [FB_AW-1:0] addr;
        logic [FB_DW-1:0] data;
    } wr_ent_t;

    fbarb_state_t     state_q;
    fbarb_state_t     state_d;
    logic [FB_AW-1:0] swp_cnt_q;
    logic [FB_AW-1:0] swp_cnt_d;
    logic [FB_DW-1:0] fill_q;
    logic [FB_DW-1:0] fill_d;
    logic             rd_p1_q;
    logic             rd_valid_q;
    logic [FB_DW-1:0] rd_data_q;

    wr_ent_t push_ent;
    wr_ent_t head_ent;
    logic    fifo_full;
    logic    fifo_empty;
    logic    push;
    logic    pop;
    logic    swp_we;

    assign push_ent = '{addr: wr_addr, data: wr_data};
    assign push     = wr_valid && wr_ready;

    fb_wr_fifo #(
        .entry_t (wr_ent_t),
        .DEPTH   (WQ_DEPTH)
    ) u_wq (
        .clk_pix (clk_pix),
        .srst_n  (srst_n),
        .push_i  (push),
        .din_i   (push_ent),
        .pop_i   (pop),
        .dout_o  (head_ent),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (wq_level)
    );

    // Slot grant: a read request always wins, otherwise the state picks the writer
    always_comb begin
        pop    = 1'b0;
        swp_we = 1'b0;
        if (srst_n && !rd_req) begin
            case (state_q)
                ST_IDLE:  pop    = !fifo_empty && (!vb_only || vblank);
                ST_DRAIN: pop    = !fifo_empty;
                ST_SWEEP: swp_we = 1'b1;
                default:  pop    = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk_pix or negedge srst_n) begin
        if (!srst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (clr_req) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (fifo_empty) begin
                    state_d = ST_SWEEP;
                end
            end
            ST_SWEEP: begin
                if (swp_we && (swp_cnt_q == {FB_AW{1'b1}})) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // RAM port and handshake outputs, all held quiet while in reset
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = rd_addr;
        ram_wdata = '0;
        wr_ready  = 1'b0;
        clr_busy  = 1'b0;
        if (srst_n) begin
            wr_ready = !fifo_full && (state_q != ST_DRAIN);
            clr_busy = (state_q != ST_IDLE);
            if (rd_req) begin
                ram_en = 1'b1;
            end else if (swp_we) begin
                ram_en    = 1'b1;
                ram_we    = 1'b1;
                ram_addr  = swp_cnt_q;
                ram_wdata = fill_q;
            end else if (pop) begin
                ram_en    = 1'b1;
                ram_we    = 1'b1;
                ram_addr  = head_ent.addr;
                ram_wdata = head_ent.data;
            end
        end
    end

    // Sweep counter stalls on read cycles and wraps to 0 after the last address
    always_comb begin
        swp_cnt_d = swp_cnt_q;
        fill_d    = fill_q;
        if (swp_we) begin
            swp_cnt_d = swp_cnt_q + FB_AW'(1);
        end
        if ((state_q == ST_IDLE) && clr_req) begin
            fill_d = clr_data;
        end
    end

    always_ff @(posedge clk_pix or negedge srst_n) begin
        if (!srst_n) begin
            swp_cnt_q <= '0;
            fill_q    <= '0;
        end else begin
            swp_cnt_q <= swp_cnt_d;
            fill_q    <= fill_d;
        end
    end

    // One register stage on the RAM output gives the two-cycle read latency
    always_ff @(posedge clk_pix or negedge srst_n) begin
        if (!srst_n) begin
            rd_p1_q    <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_p1_q    <= rd_req;
            rd_valid_q <= rd_p1_q;
            if (rd_p1_q) begin
                rd_data_q <= ram_rdata;
            end
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_fb_arbiter.sv
// Directed bench for fb_arbiter with a behavioural 1-cycle-latency RAM and a write log.
module tb_fb_arbiter;

    localparam int AW    = 11;
    localparam int DW    = 4;
    localparam int DEPTH = 4;
    localparam int NWORD = 2 ** AW;

    logic          clk_pix = 1'b0;
    logic          srst_n;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          wr_valid;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          vblank;
    logic          vb_only;
    logic          clr_req;
    logic [DW-1:0] clr_data;
    logic          clr_busy;
    logic          ram_en;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;
    logic [$clog2(DEPTH):0] wq_level;

    int n_cmp = 0;
    int n_bad = 0;

    logic [DW-1:0] mem [NWORD];
    int            wcount [NWORD];
    int            log_a [$];
    int            log_d [$];
    int            log_c [$];
    int            cyc = 0;

    fb_arbiter #(.FB_AW(AW), .FB_DW(DW), .WQ_DEPTH(DEPTH)) dut (
        .clk_pix   (clk_pix),
        .srst_n    (srst_n),
        .rd_req    (rd_req),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .vblank    (vblank),
        .vb_only   (vb_only),
        .clr_req   (clr_req),
        .clr_data  (clr_data),
        .clr_busy  (clr_busy),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .wq_level  (wq_level)
    );

    always #5 clk_pix = ~clk_pix;

    // Single-port RAM model plus a log of every committed write
    always @(posedge clk_pix) begin
        if (ram_en && ram_we) begin
            mem[ram_addr] = ram_wdata;
            wcount[ram_addr] = wcount[ram_addr] + 1;
            log_a.push_back(int'(ram_addr));
            log_d.push_back(int'(ram_wdata));
            log_c.push_back(cyc);
        end else if (ram_en) begin
            ram_rdata <= mem[ram_addr];
        end
        cyc = cyc + 1;
    end

    task automatic tick();
        @(posedge clk_pix);
        #1;
    endtask

    task automatic clear_logs();
        log_a.delete();
        log_d.delete();
        log_c.delete();
        for (int i = 0; i < NWORD; i++) wcount[i] = 0;
    endtask

    task automatic push_one(input int a, input int d);
        wr_valid = 1'b1;
        wr_addr  = AW'(a);
        wr_data  = DW'(d);
        n_cmp++;
        if (wr_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL push_ready addr=%0h: got %b want 1", a, wr_ready);
        end
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic test_reset();
        srst_n = 1'b0;
        rd_req = 1'b1; rd_addr = 11'h005;
        wr_valid = 1'b1; clr_req = 1'b1; clr_data = 4'hF;
        tick(); tick();
        n_cmp++; if (ram_en !== 1'b0)   begin n_bad++; $display("FAIL rst_ram_en: got %b want 0", ram_en); end
        n_cmp++; if (ram_we !== 1'b0)   begin n_bad++; $display("FAIL rst_ram_we: got %b want 0", ram_we); end
        n_cmp++; if (wr_ready !== 1'b0) begin n_bad++; $display("FAIL rst_wr_ready: got %b want 0", wr_ready); end
        n_cmp++; if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL rst_rd_valid: got %b want 0", rd_valid); end
        n_cmp++; if (rd_data !== 4'h0)  begin n_bad++; $display("FAIL rst_rd_data: got %h want 0", rd_data); end
        n_cmp++; if (clr_busy !== 1'b0) begin n_bad++; $display("FAIL rst_clr_busy: got %b want 0", clr_busy); end
        n_cmp++; if (wq_level !== 3'd0) begin n_bad++; $display("FAIL rst_wq_level: got %0d want 0", wq_level); end
        rd_req = 1'b0; wr_valid = 1'b0; clr_req = 1'b0;
        srst_n = 1'b1;
        tick();
        n_cmp++; if (wr_ready !== 1'b1) begin n_bad++; $display("FAIL post_rst_wr_ready: got %b want 1", wr_ready); end
        n_cmp++; if (clr_busy !== 1'b0) begin n_bad++; $display("FAIL post_rst_clr_busy: got %b want 0", clr_busy); end
    endtask

    task automatic test_read();
        mem[5] = 4'h9;
        rd_req = 1'b1; rd_addr = 11'h005;
        #1;
        n_cmp++;
        if (ram_en !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 11'h005) begin
            n_bad++; $display("FAIL read_port: got en=%b we=%b addr=%h want 1 0 005", ram_en, ram_we, ram_addr);
        end
        tick();
        rd_req = 1'b0;
        n_cmp++; if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL read_lat1: got valid=%b want 0", rd_valid); end
        tick();
        n_cmp++;
        if (rd_valid !== 1'b1 || rd_data !== 4'h9) begin
            n_bad++; $display("FAIL read_lat2: got valid=%b data=%h want 1 9", rd_valid, rd_data);
        end
        tick();
        n_cmp++;
        if (rd_valid !== 1'b0 || rd_data !== 4'h9) begin
            n_bad++; $display("FAIL read_hold: got valid=%b data=%h want 0 9", rd_valid, rd_data);
        end
    endtask

    task automatic test_queue_under_read();
        clear_logs();
        rd_req = 1'b1; rd_addr = 11'h005;
        for (int i = 0; i < 4; i++) push_one(16 + i, i + 1);
        n_cmp++; if (wq_level !== 3'd4) begin n_bad++; $display("FAIL q_level_full: got %0d want 4", wq_level); end
        n_cmp++; if (wr_ready !== 1'b0) begin n_bad++; $display("FAIL q_ready_full: got %b want 0", wr_ready); end
        n_cmp++; if (log_a.size() != 0) begin n_bad++; $display("FAIL q_blocked: got %0d writes want 0", log_a.size()); end
        rd_req = 1'b0;
        repeat (4) tick();
        n_cmp++; if (wq_level !== 3'd0) begin n_bad++; $display("FAIL q_level_drained: got %0d want 0", wq_level); end
        n_cmp++;
        if (log_a.size() != 4) begin
            n_bad++; $display("FAIL q_write_count: got %0d want 4", log_a.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (log_a[i] != 16 + i || log_d[i] != i + 1) begin
                    n_bad++; $display("FAIL q_order[%0d]: got %0h/%0h want %0h/%0h", i, log_a[i], log_d[i], 16 + i, i + 1);
                end
            end
            n_cmp++;
            if (log_c[3] - log_c[0] != 3) begin
                n_bad++; $display("FAIL q_consecutive: got span %0d want 3", log_c[3] - log_c[0]);
            end
        end
    endtask

    task automatic test_vblank_gate();
        clear_logs();
        vb_only = 1'b1; vblank = 1'b0;
        push_one(32, 5);
        push_one(33, 6);
        repeat (3) tick();
        n_cmp++; if (log_a.size() != 0) begin n_bad++; $display("FAIL vb_gated: got %0d writes want 0", log_a.size()); end
        n_cmp++; if (wq_level !== 3'd2) begin n_bad++; $display("FAIL vb_level: got %0d want 2", wq_level); end
        vblank = 1'b1;
        repeat (2) tick();
        n_cmp++;
        if (log_a.size() != 2 || log_a[0] != 32 || log_d[0] != 5 || log_a[1] != 33 || log_d[1] != 6) begin
            n_bad++; $display("FAIL vb_commit: got %0d writes want 2 (20/5,21/6)", log_a.size());
        end
        n_cmp++; if (wq_level !== 3'd0) begin n_bad++; $display("FAIL vb_level_after: got %0d want 0", wq_level); end
        vblank = 1'b0;
    endtask

    task automatic test_clear_drain();
        int busy;
        int nrdy;
        int bad;
        push_one(48, 7);
        push_one(49, 8);
        push_one(50, 9);
        n_cmp++; if (wq_level !== 3'd3) begin n_bad++; $display("FAIL clr_prefill: got %0d want 3", wq_level); end
        clear_logs();
        clr_req = 1'b1; clr_data = 4'h0;
        tick();
        clr_req = 1'b0;
        busy = 0; nrdy = 0;
        while (clr_busy && busy < 5000) begin
            if (!wr_ready) nrdy++;
            if (busy == 100) begin
                clr_req = 1'b1; clr_data = 4'hF;
            end else begin
                clr_req = 1'b0;
            end
            busy++;
            tick();
        end
        clr_req = 1'b0;
        n_cmp++; if (busy != 2052) begin n_bad++; $display("FAIL clr_busy_len: got %0d want 2052", busy); end
        n_cmp++; if (nrdy != 4)    begin n_bad++; $display("FAIL clr_drain_notready: got %0d want 4", nrdy); end
        n_cmp++;
        if (log_a.size() != 2051) begin
            n_bad++; $display("FAIL clr_write_count: got %0d want 2051", log_a.size());
        end else begin
            n_cmp++;
            if (log_a[0] != 48 || log_d[0] != 7 || log_a[1] != 49 || log_d[1] != 8 || log_a[2] != 50 || log_d[2] != 9) begin
                n_bad++; $display("FAIL clr_drain_first: got %0h/%0h %0h/%0h %0h/%0h", log_a[0], log_d[0], log_a[1], log_d[1], log_a[2], log_d[2]);
            end
            bad = 0;
            for (int k = 0; k < NWORD; k++) begin
                if (log_a[3 + k] != k || log_d[3 + k] != 0) bad++;
            end
            n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL clr_sweep_seq: got %0d bad entries want 0", bad); end
        end
        n_cmp++; if (wr_ready !== 1'b1) begin n_bad++; $display("FAIL clr_idle_ready: got %b want 1", wr_ready); end
        vb_only = 1'b0;
    endtask

    task automatic test_sweep_reads();
        int n;
        int bad;
        int nreads;
        int j;
        logic p1, p2;
        logic [DW-1:0] e1, e2, ex;
        logic rdv;
        logic [AW-1:0] ad;
        clear_logs();
        clr_req = 1'b1; clr_data = 4'hA;
        tick();
        clr_req = 1'b0;
        n = 0; bad = 0; nreads = 0;
        p1 = 1'b0; p2 = 1'b0; e1 = '0; e2 = '0;
        while (clr_busy && n < 5000) begin
            if (rd_valid !== p2) bad++;
            else if (p2 && rd_data !== e2) bad++;
            rdv = (n % 2 == 0) && (n < 200);
            j   = n / 2;
            ad  = (j % 2 == 1) ? AW'(0) : AW'(NWORD - 1 - j);
            ex  = (j % 2 == 1) ? 4'hA : 4'h0;
            rd_req = rdv; rd_addr = ad;
            p2 = p1; e2 = e1; p1 = rdv; e1 = ex;
            if (rdv) nreads++;
            n++;
            tick();
        end
        rd_req = 1'b0;
        n_cmp++; if (bad != 0)     begin n_bad++; $display("FAIL swr_read_data: got %0d bad reads want 0", bad); end
        n_cmp++; if (nreads != 100) begin n_bad++; $display("FAIL swr_read_count: got %0d want 100", nreads); end
        n_cmp++; if (n != 2148)    begin n_bad++; $display("FAIL swr_busy_len: got %0d want 2148", n); end
        bad = 0;
        for (int a = 0; a < NWORD; a++) begin
            if (wcount[a] != 1 || mem[a] !== 4'hA) bad++;
        end
        n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL swr_once_each: got %0d bad addresses want 0", bad); end
    endtask

    task automatic test_reset_mid_sweep();
        int nlog;
        clr_req = 1'b1; clr_data = 4'h5;
        tick();
        clr_req = 1'b0;
        repeat (20) tick();
        push_one(64, 1);
        push_one(65, 2);
        n_cmp++; if (wq_level !== 3'd2) begin n_bad++; $display("FAIL mid_level: got %0d want 2", wq_level); end
        n_cmp++; if (clr_busy !== 1'b1) begin n_bad++; $display("FAIL mid_busy: got %b want 1", clr_busy); end
        srst_n = 1'b0;
        #1;
        n_cmp++;
        if (ram_en !== 1'b0 || ram_we !== 1'b0 || clr_busy !== 1'b0 || wr_ready !== 1'b0) begin
            n_bad++; $display("FAIL mid_rst_ctl: got en=%b we=%b busy=%b rdy=%b want 0 0 0 0", ram_en, ram_we, clr_busy, wr_ready);
        end
        n_cmp++;
        if (wq_level !== 3'd0 || rd_valid !== 1'b0 || rd_data !== 4'h0) begin
            n_bad++; $display("FAIL mid_rst_state: got lvl=%0d valid=%b data=%h want 0 0 0", wq_level, rd_valid, rd_data);
        end
        nlog = log_a.size();
        repeat (3) tick();
        srst_n = 1'b1;
        repeat (5) tick();
        n_cmp++; if (log_a.size() != nlog) begin n_bad++; $display("FAIL mid_no_writes: got %0d extra writes want 0", log_a.size() - nlog); end
        n_cmp++;
        if (clr_busy !== 1'b0 || wq_level !== 3'd0 || wr_ready !== 1'b1) begin
            n_bad++; $display("FAIL mid_after: got busy=%b lvl=%0d rdy=%b want 0 0 1", clr_busy, wq_level, wr_ready);
        end
    endtask

    initial begin
        srst_n = 1'b0; rd_req = 1'b0; rd_addr = '0;
        wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
        vblank = 1'b0; vb_only = 1'b0; clr_req = 1'b0; clr_data = '0;
        for (int i = 0; i < NWORD; i++) wcount[i] = 0;
        test_reset();
        test_read();
        test_queue_under_read();
        test_vblank_gate();
        test_clear_drain();
        test_sweep_reads();
        test_reset_mid_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
